// File: rtl/spi_slave_core.sv
// SPI mode-0 slave core: 8-bit MSB-first words, pin synchronizers, one-entry TX
// buffer and a single-entry RX output register with valid/ready handshakes.
// Optional sticky error flags (tx_underrun, rx_overrun, err_clr) are enabled by
// defining SPI_SLAVE_ERR_FLAGS_EN.
module spi_slave_core #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  ,
  output logic       tx_underrun,
  output logic       rx_overrun,
  input  logic       err_clr
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q, cs_prev_q;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall, shift_en, tx_load;

  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] txbuf_q, txbuf_d;
  logic       txbuf_full_q, txbuf_full_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wrap_q, wrap_d;   // byte finished; next sclk fall reloads TX
  logic       done_q, done_d;   // one-cycle pulse after the 8th rising edge
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // Pin synchronizers plus one-cycle-delayed copies for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // FSM next state; a deselect wins over everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cs_fall) state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: state_d = StShift;
      default: state_d = StIdle;
    endcase
    if (cs_s) state_d = StIdle;
  end

  assign shift_en = (state_q == StShift) & ~cs_s;
  assign tx_load  = ~cs_s & ((state_q == StLoad) | (shift_en & sclk_fall & wrap_q));

  // Shift registers, TX buffer and RX output register next state.
  always_comb begin
    tx_sr_d      = tx_sr_q;
    txbuf_d      = txbuf_q;
    txbuf_full_d = txbuf_full_q;
    rx_sr_d      = rx_sr_q;
    cnt_d        = cnt_q;
    wrap_d       = wrap_q;
    done_d       = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;

    if (tx_load) begin
      tx_sr_d      = txbuf_full_q ? txbuf_q : 8'hFF;
      txbuf_full_d = 1'b0;
      wrap_d       = 1'b0;
    end else if (shift_en && sclk_fall) begin
      tx_sr_d = {tx_sr_q[6:0], 1'b1};
    end

    if (tx_valid && !txbuf_full_q) begin
      txbuf_d      = tx_data;
      txbuf_full_d = 1'b1;
    end

    if (shift_en && sclk_rise) begin
      rx_sr_d = {rx_sr_q[6:0], mosi_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        done_d = 1'b1;
        wrap_d = 1'b1;
      end
    end

    // Deselect drops any partial byte; the TX buffer is left untouched.
    if (cs_s) begin
      cnt_d   = 3'd0;
      wrap_d  = 1'b0;
      tx_sr_d = 8'hFF;
    end

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (done_q && (!rx_valid_q || rx_ready)) begin
      rx_data_d  = rx_sr_q;
      rx_valid_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      tx_sr_q      <= 8'hFF;
      txbuf_q      <= 8'h00;
      txbuf_full_q <= 1'b0;
      rx_sr_q      <= 8'h00;
      cnt_q        <= 3'd0;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_sr_q      <= tx_sr_d;
      txbuf_q      <= txbuf_d;
      txbuf_full_q <= txbuf_full_d;
      rx_sr_q      <= rx_sr_d;
      cnt_q        <= cnt_d;
      wrap_q       <= wrap_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  assign spi_miso    = (state_q == StIdle) ? 1'b1 : tx_sr_q[7];
  assign spi_miso_oe = (state_q != StIdle);
  assign tx_ready    = ~txbuf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic underrun_q, underrun_d, overrun_q, overrun_d;

  // Sticky error flags; a clear beats a same-cycle set.
  always_comb begin
    underrun_d = underrun_q | (tx_load & ~txbuf_full_q);
    overrun_d  = overrun_q | (done_q & rx_valid_q & ~rx_ready);
    if (err_clr) begin
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_underrun = underrun_q;
  assign rx_overrun  = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: directed scenarios followed by random frames
// checked against a byte-level model of the TX buffer and RX stream.
module tb_spi_slave_core;

  localparam int HALF = 6;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid;
  logic [7:0] rx_data;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic       err_clr = 1'b0;
  logic       tx_underrun, rx_overrun;
`endif

  spi_slave_core #(.SYNC_STAGES(2)) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .spi_sclk    (sclk),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_miso_oe (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    ,
    .tx_underrun (tx_underrun),
    .rx_overrun  (rx_overrun),
    .err_clr     (err_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] rx_got[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bytes handed to the consumer.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
  end

  task automatic set_rx_ready(input logic v);
    @(posedge clk);
    #2 rx_ready = v;
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_begin();
    @(negedge clk);
    sclk = 1'b0;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask
`endif

  // Master side of one word; optionally refills the TX buffer mid-byte.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit do_push,
                          input logic [7:0] pv, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      repeat (HALF) @(negedge clk);
      mi[7-i] = miso;
      sclk = 1'b1;
      if (do_push && i == 2) begin
        check_val("tx_ready_mid", {31'd0, tx_ready}, 32'd1);
        push_tx(pv);
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] exp);
    check_val({tag, "_cnt"}, rx_got.size(), 1);
    if (rx_got.size() > 0) check_val(tag, {24'd0, rx_got.pop_front()}, {24'd0, exp});
    rx_got.delete();
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] mo_b[3];
    logic [7:0] exp_miso;
    logic       m_full;
    logic [7:0] m_val;
    logic       m_und;
    int         nb;
    bit         dp;
    logic [7:0] pv;

    repeat (3) @(negedge clk);
    // Reset state
    check_val("rst_miso", {31'd0, miso}, 32'd1);
    check_val("rst_oe", {31'd0, miso_oe}, 32'd0);
    check_val("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check_val("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_val("rst_rx_data", {24'd0, rx_data}, 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte A5 out, 3C in
    push_tx(8'hA5);
    check_val("a5_tx_ready", {31'd0, tx_ready}, 32'd0);
    cs_begin();
    check_val("a5_oe", {31'd0, miso_oe}, 32'd1);
    check_val("a5_rx_valid_pre", {31'd0, rx_valid}, 32'd0);
    spi_xfer(8'h3C, 8, 1'b0, 8'h00, mi);
    repeat (4) @(negedge clk);
    check_val("a5_miso", {24'd0, mi}, 32'hA5);
    check_val("a5_rx_valid", {31'd0, rx_valid}, 32'd1);
    check_val("a5_rx_data", {24'd0, rx_data}, 32'h3C);
    cs_end();
    check_val("a5_oe_idle", {31'd0, miso_oe}, 32'd0);
    check_val("a5_miso_idle", {31'd0, miso}, 32'd1);
    set_rx_ready(1'b1);
    set_rx_ready(1'b0);
    @(negedge clk);
    check_val("a5_rx_consumed", {31'd0, rx_valid}, 32'd0);
    pop_rx("a5_rx_pop", 8'h3C);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    pulse_err_clr();
`endif

    // Back-to-back 12, 34 with mid-byte refill
    set_rx_ready(1'b1);
    push_tx(8'h12);
    cs_begin();
    spi_xfer(8'h5A, 8, 1'b1, 8'h34, mi);
    check_val("b2b_byte0", {24'd0, mi}, 32'h12);
    repeat (5) @(negedge clk);
    check_val("b2b_tx_ready_gap", {31'd0, tx_ready}, 32'd1);
    spi_xfer(8'hA6, 8, 1'b0, 8'h00, mi);
    check_val("b2b_byte1", {24'd0, mi}, 32'h34);
    cs_end();
    check_val("b2b_rx_cnt", rx_got.size(), 2);
    if (rx_got.size() == 2) begin
      check_val("b2b_rx0", {24'd0, rx_got[0]}, 32'h5A);
      check_val("b2b_rx1", {24'd0, rx_got[1]}, 32'hA6);
    end
    rx_got.delete();

    // Underrun: empty buffer gives FF
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    pulse_err_clr();
    check_val("ur_clear0", {31'd0, tx_underrun}, 32'd0);
`endif
    cs_begin();
    spi_xfer(8'h00, 8, 1'b0, 8'h00, mi);
    cs_end();
    check_val("ur_miso", {24'd0, mi}, 32'hFF);
    rx_got.delete();
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    check_val("ur_flag", {31'd0, tx_underrun}, 32'd1);
    pulse_err_clr();
    check_val("ur_flag_clr", {31'd0, tx_underrun}, 32'd0);
`endif

    // Overrun: consumer stalled across two bytes
    set_rx_ready(1'b0);
    cs_begin();
    spi_xfer(8'h11, 8, 1'b0, 8'h00, mi);
    spi_xfer(8'h22, 8, 1'b0, 8'h00, mi);
    cs_end();
    check_val("or_rx_valid", {31'd0, rx_valid}, 32'd1);
    check_val("or_rx_data", {24'd0, rx_data}, 32'h11);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    check_val("or_flag", {31'd0, rx_overrun}, 32'd1);
    pulse_err_clr();
    check_val("or_flag_clr", {31'd0, rx_overrun}, 32'd0);
`endif
    set_rx_ready(1'b1);
    repeat (2) @(negedge clk);
    pop_rx("or_rx_pop", 8'h11);

    // Deselect after 5 bits, then a clean C3 frame
    cs_begin();
    spi_xfer(8'hFF, 5, 1'b0, 8'h00, mi);
    cs_end();
    check_val("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_val("abort_rx_cnt", rx_got.size(), 0);
    check_val("abort_oe", {31'd0, miso_oe}, 32'd0);
    cs_begin();
    spi_xfer(8'hC3, 8, 1'b0, 8'h00, mi);
    cs_end();
    pop_rx("abort_next_rx", 8'hC3);

    // Reset mid-byte
    push_tx(8'h5A);
    cs_begin();
    spi_xfer(8'hE7, 4, 1'b0, 8'h00, mi);
    @(negedge clk);
    rstn = 1'b0;
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("mrst_miso", {31'd0, miso}, 32'd1);
    check_val("mrst_oe", {31'd0, miso_oe}, 32'd0);
    check_val("mrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check_val("mrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_val("mrst_rx_data", {24'd0, rx_data}, 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    rx_got.delete();
    cs_begin();
    spi_xfer(8'hE7, 8, 1'b0, 8'h00, mi);
    cs_end();
    check_val("mrst_next_miso", {24'd0, mi}, 32'hFF);
    pop_rx("mrst_next_rx", 8'hE7);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    pulse_err_clr();
`endif

    // Random frames against a byte-level model: each word boundary (frame
    // start and the falling edge after every 8th bit) consumes the buffer.
    m_full = 1'b0;
    m_val  = 8'h00;
    for (int f = 0; f < 20; f++) begin
      m_und = 1'b0;
      nb = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        m_val = 8'($urandom);
        check_val("rnd_tx_ready_pre", {31'd0, tx_ready}, {31'd0, ~m_full});
        push_tx(m_val);
        m_full = 1'b1;
      end
      cs_begin();
      exp_miso = m_full ? m_val : 8'hFF;
      m_und = m_und | ~m_full;
      m_full = 1'b0;
      for (int b = 0; b < nb; b++) begin
        mo_b[b] = 8'($urandom);
        dp = ($urandom_range(0, 1) == 1);
        pv = 8'($urandom);
        spi_xfer(mo_b[b], 8, dp, pv, mi);
        check_val("rnd_miso", {24'd0, mi}, {24'd0, exp_miso});
        if (dp) begin
          m_full = 1'b1;
          m_val  = pv;
        end
        exp_miso = m_full ? m_val : 8'hFF;
        m_und = m_und | ~m_full;
        m_full = 1'b0;
      end
      cs_end();
      check_val("rnd_rx_cnt", rx_got.size(), nb);
      for (int b = 0; b < nb; b++) begin
        if (rx_got.size() > 0) check_val("rnd_rx", {24'd0, rx_got.pop_front()}, {24'd0, mo_b[b]});
      end
      rx_got.delete();
`ifdef SPI_SLAVE_ERR_FLAGS_EN
      check_val("rnd_underrun", {31'd0, tx_underrun}, {31'd0, m_und});
      pulse_err_clr();
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of flops in each pin synchronizer (legal range 2..4).
REQ-002 clk  input  1  system clock; all logic is in this single domain.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 spi_sclk  input  1  SPI clock from the external master, asynchronous to clk.
REQ-005 spi_cs_n  input  1  chip select from the master, active low, asynchronous.
REQ-006 spi_mosi  input  1  serial data from the master.
REQ-007 spi_miso  output  1  serial data to the master.
REQ-008 spi_miso_oe  output  1  MISO output enable; high only while selected.
REQ-009 tx_data  input  8  next byte to return to the master.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  one-entry TX buffer is empty; a transfer occurs when tx_valid && tx_ready.
REQ-012 rx_data  output  8  last received byte.
REQ-013 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-014 rx_ready  input  1  consumer accepts rx_data; a transfer occurs when rx_valid && rx_ready.

Function
REQ-015 The block SHALL implement SPI mode 0 (CPOL=0, CPHA=0), 8-bit words, MSB first.
REQ-016 spi_sclk, spi_cs_n and spi_mosi SHALL each pass through a SYNC_STAGES-flop synchronizer; edges SHALL be detected by comparing the synchronized value with a one-cycle-delayed copy.
REQ-017 The block SHALL operate correctly when the clk frequency is at least 8x the spi_sclk frequency.
REQ-018 The FSM states SHALL be IDLE, LOAD and SHIFT; IDLE->LOAD on synchronized cs_n falling; LOAD->SHIFT after one cycle; any state->IDLE on synchronized cs_n high.
REQ-019 In LOAD and on each byte wrap, the TX shift register SHALL take the TX buffer if it is full (buffer becomes empty); otherwise it SHALL take 8'hFF and flag an underrun.
REQ-020 spi_miso SHALL equal shift-register bit 7; the register SHALL shift left on each detected sclk falling edge while in SHIFT.
REQ-021 On each detected sclk rising edge in SHIFT, the sampled MOSI SHALL be shifted into the RX register and a 3-bit counter incremented; the counter SHALL wrap 7->0.
REQ-022 On the 8th rising edge, rx_data/rx_valid SHALL update in the next clk cycle; the next TX byte SHALL be loaded on the following sclk falling edge instead of a shift.
REQ-023 If the 8th bit completes while rx_valid=1 and rx_ready=0, the new byte SHALL be dropped and rx_data kept (overrun); with rx_ready=1 in that same cycle, the new byte SHALL replace the old one without loss.
REQ-024 A cs_n deassert mid-byte SHALL discard the partial byte: no rx_valid, counter reset to 0, TX buffer contents retained.
REQ-025 spi_miso_oe SHALL be 1 in LOAD and SHIFT, and 0 in IDLE; spi_miso SHALL be 1 in IDLE.
REQ-026 tx_valid with tx_ready=0 SHALL be ignored; the TX buffer SHALL never be overwritten while full.

Reset
REQ-027 On rstn low: state=IDLE, counter=0, shift registers=8'hFF/8'h00 (TX/RX), synchronizers=cs_n 1 and others 0, rx_valid=0, rx_data=0, tx_ready=1, spi_miso=1, spi_miso_oe=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; after release, the block SHALL wait in IDLE for a fresh cs_n falling edge.

Configuration
REQ-029 Macro SPI_SLAVE_ERR_FLAGS_EN: when defined, adds outputs tx_underrun and rx_overrun (1 bit each), sticky from REQ-019/REQ-023 events, plus input err_clr (1 bit), which clears both in one cycle (err_clr has priority over a same-cycle set); reset value is 0.
REQ-030 Without SPI_SLAVE_ERR_FLAGS_EN, those ports and registers SHALL not exist, and underrun/overrun behaviour is otherwise identical.

Verification
REQ-031 Load tx_data=8'hA5, then send master frame MOSI=8'h3C at clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid rises after the 8th rising edge.
REQ-032 Two back-to-back bytes with TX buffer pre-refilled (8'h12, 8'h34) -> master receives 8'h12 then 8'h34; tx_ready pulses high between the bytes.
REQ-033 Empty TX buffer at cs_n fall -> master receives 8'hFF; tx_underrun=1 (macro on); err_clr clears it.
REQ-034 rx_ready held 0 across two received bytes 8'h11, 8'h22 -> rx_data stays 8'h11; rx_overrun=1.
REQ-035 cs_n raised after 5 bits -> no rx_valid and spi_miso_oe=0; the next full frame 8'hC3 is received correctly.
REQ-036 rstn pulsed low mid-byte -> all outputs at REQ-027 values; the next frame decodes correctly.
